// File: rtl/d_flip_flop_rst_pkg.sv
// Shared constants and types for the d_flip_flop_rst storage register.
package d_flip_flop_rst_pkg;

    localparam int unsigned DFF_MAX_WIDTH       = 64;
    localparam int unsigned DFF_RST_SYNC_STAGES = 2;

    typedef logic [DFF_MAX_WIDTH-1:0] dff_word_t;

    // Legal data widths are 1..DFF_MAX_WIDTH.
    function automatic bit dff_width_ok(input int unsigned w);
        return (w >= 1) && (w <= DFF_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/d_flip_flop_rst_reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer (active-high).
// Only compiled when D_FLIP_FLOP_RST_SYNC_DEASSERT_EN is defined.
`ifdef D_FLIP_FLOP_RST_SYNC_DEASSERT_EN
module d_flip_flop_rst_reset_sync
    import d_flip_flop_rst_pkg::*;
#(
    parameter int unsigned STAGES = DFF_RST_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    if (STAGES < 2) begin : g_stages_check
        $error("d_flip_flop_rst_reset_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;

    // Stages power into the asserted state; a zero walks in once rst is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[STAGES-1];

endmodule
`endif

// File: rtl/d_flip_flop_rst.sv
// Parameterizable D register with asynchronous active-high reset to RESET_VALUE.
// Define D_FLIP_FLOP_RST_SYNC_DEASSERT_EN to release reset through a 2-stage synchronizer.
module d_flip_flop_rst
    import d_flip_flop_rst_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!dff_width_ok(WIDTH)) begin : g_width_check
        $error("d_flip_flop_rst: WIDTH must be in 1..%0d", DFF_MAX_WIDTH);
    end

    localparam dff_word_t        RESET_WORD = dff_word_t'(RESET_VALUE);
    localparam logic [WIDTH-1:0] RESET_Q    = RESET_WORD[WIDTH-1:0];

    logic rst_int;

`ifdef D_FLIP_FLOP_RST_SYNC_DEASSERT_EN
    // Assertion still passes straight through; only the release is retimed.
    d_flip_flop_rst_reset_sync #(
        .STAGES (DFF_RST_SYNC_STAGES)
    ) u_reset_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (rst_int)
    );
`else
    assign rst_int = rst;
`endif

    // Data flops: every rising edge captures, reset wins immediately.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            q <= RESET_Q;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_d_flip_flop_rst.sv
// Directed self-checking bench for d_flip_flop_rst (WIDTH=1 and WIDTH=8 instances).
module tb_d_flip_flop_rst;

`ifdef D_FLIP_FLOP_RST_SYNC_DEASSERT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [0:0] d;
    logic [0:0] q;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;

    int tests_run;
    int tests_failed;

    d_flip_flop_rst dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );

    d_flip_flop_rst #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk (clk),
        .rst (rst8),
        .d   (d8),
        .q   (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            d  = 1'(i % 2);
            d8 = 8'(i * 37);
            #2;
            tests_run++;
            if (q !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: q=%b expected 0", i, q);
            end
            tests_run++;
            if (q8 !== 8'hA5) begin
                tests_failed++;
                $display("FAIL reset_hold8[%0d]: q8=%h expected a5", i, q8);
            end
            #3;
        end
    endtask

    task automatic test_capture();
        logic vec [6];
        logic prev;
        vec = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        d   = 1'b1;
        rst = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (q !== ((k == LAT) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL release_edge%0d: q=%b expected %b", k, q, (k == LAT));
            end
        end
        prev = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d = vec[i];
            #1;
            tests_run++;
            if (q !== prev) begin
                tests_failed++;
                $display("FAIL hold_at_negedge[%0d]: q=%b expected %b", i, q, prev);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (q !== vec[i]) begin
                tests_failed++;
                $display("FAIL capture[%0d]: q=%b expected %b", i, q, vec[i]);
            end
            #1 d = ~vec[i];
            #1;
            tests_run++;
            if (q !== vec[i]) begin
                tests_failed++;
                $display("FAIL d_glitch[%0d]: q=%b expected %b", i, q, vec[i]);
            end
            prev = vec[i];
        end
    endtask

    task automatic test_async_assert();
        @(negedge clk);
        d = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (q !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_assert: q=%b expected 1", q);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (q !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_assert: q=%b expected 0", q);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (q !== 1'b0) begin
            tests_failed++;
            $display("FAIL assert_hold: q=%b expected 0", q);
        end
    endtask

    task automatic test_width8();
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_reset: q8=%h expected a5", q8);
        end
        @(negedge clk);
        d8   = 8'h3C;
        rst8 = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (q8 !== ((k == LAT) ? 8'h3C : 8'hA5)) begin
                tests_failed++;
                $display("FAIL w8_release_edge%0d: q8=%h", k, q8);
            end
        end
        @(negedge clk);
        d8 = 8'h5A;
        @(posedge clk);
        #1;
        tests_run++;
        if (q8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL w8_capture: q8=%h expected 5a", q8);
        end
        #1 rst8 = 1'b1;
        #1;
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_async_assert: q8=%h expected a5", q8);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (q8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL w8_assert_hold: q8=%h expected a5", q8);
        end
    endtask

    // Release lands in the NBA region of a rising edge, so that edge still sees reset.
    task automatic test_coincident();
        @(negedge clk);
        d = 1'b1;
        @(posedge clk);
        rst <= 1'b0;
        #1;
        tests_run++;
        if (q !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_edge: q=%b expected 0", q);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (q !== ((k == LAT) ? 1'b1 : 1'b0)) begin
                tests_failed++;
                $display("FAIL coincident_edge%0d: q=%b expected %b", k, q, (k == LAT));
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst  = 1'b1;
        rst8 = 1'b1;
        d    = 1'b0;
        d8   = 8'h00;
        test_reset();
        test_capture();
        test_async_assert();
        test_width8();
        test_coincident();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/d_flip_flop_rst.md
# d_flip_flop_rst

Parameterizable edge-triggered D-type storage register with an asynchronous, active-high reset. It is the basic state-holding primitive for datapath staging and control flags. It captures `d` on every rising edge of `clk` and forces `q` to a fixed reset value whenever `rst` is high. The single-bit default is a drop-in D flip-flop.

## Interface
- `WIDTH`, default 1: data width in bits; legal range 1..64.
- `RESET_VALUE`, default `'0` (WIDTH bits): value driven on `q` while in reset.
- `clk` input, 1 bit: clock; all capture on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high. Assertion takes effect immediately, independent of `clk`.
- `d` input, WIDTH bits: data to capture.
- `q` output, WIDTH bits: registered data, driven directly from flops with no combinational path from `d`.

## Operation
- `rst` = 1: `q` = RESET_VALUE immediately. The value holds for as long as `rst` is high. `d` and `clk` edges are ignored.
- `rst` = 0: on each rising `clk` edge, `q` takes the value of `d` sampled at that edge. Between edges `q` holds.
- There is no enable; every edge captures. Wider designs gate `d` externally.
- All WIDTH bits behave identically and independently. There is no arithmetic.
- Falling clock edges have no effect.
- `d` toggling between edges has no effect; only the value at the rising edge counts.
- Power-up value before the first reset is undefined (X in simulation). A user must assert `rst` before relying on `q`.

## Timing
- Capture latency: 1 clock. `d` at rising edge n appears on `q` after edge n, with clock-to-q delay only.
- Reset assertion: `q` goes to RESET_VALUE in the same time step `rst` rises, even mid-cycle.
- Reset deassertion (macro off):
  - The first rising edge with `rst` = 0 captures `d`.
  - If `rst` falls exactly at a rising edge, that edge is still in reset and `q` stays RESET_VALUE.
  - Capture starts at the next edge.
- Reset asserted mid-operation discards the held value. No history survives.
- `d` must meet setup/hold around the rising edge. `d` changes coincident with the falling edge are legal.

## Configuration
- Macro `D_FLIP_FLOP_RST_SYNC_DEASSERT_EN`.
- Defined:
  - `rst` passes through an internal 2-stage reset synchronizer clocked by `clk`.
  - Assertion remains asynchronous: `q` = RESET_VALUE immediately.
  - Deassertion is released to the data flops only after 2 rising edges with `rst` = 0.
  - The first capture of `d` therefore happens on the 3rd rising edge after `rst` falls.
  - Synchronizer stages reset to the asserted state.
- Undefined: `rst` drives the data flops directly as described in Timing. No synchronizer logic is present.

## Structure
- Shared package `d_flip_flop_rst_pkg`:
  - `DFF_MAX_WIDTH` = 64.
  - `DFF_RST_SYNC_STAGES` = 2.
  - Typedef `dff_word_t` (logic [DFF_MAX_WIDTH-1:0]) for RESET_VALUE checking.
- Elaboration-time check: error if WIDTH < 1 or WIDTH > DFF_MAX_WIDTH.
- One sub-module `reset_sync`:
  - Asynchronous-assert, synchronous-deassert synchronizer with a parameter for stage count.
  - Instantiated only under the macro.
- Data register: a single always block sensitive to posedge `clk` and posedge `rst`.

## Test plan
Clock period 2 time units; `clk` starts at 0 and toggles every 1. WIDTH=1 and RESET_VALUE=0 unless stated.
- Reset hold: `rst`=1 from t=0 to t=8 while `d` toggles 1/0 every time unit -> `q`=0 throughout.
- Capture after release (macro off): `rst` falls at t=8; `d`=1 at t=9, 0 at t=10, 1 at t=11, 0 at t=12 -> `q` updates only at rising edges to the `d` value at each edge; `q` never changes on falling edges.
- Async assert: `q`=1 and `rst` pulsed high at t=15.5 (mid-cycle) -> `q`=0 at t=15.5 with no clock edge needed.
- Parameterized: WIDTH=8, RESET_VALUE=8'hA5:
  - In reset -> `q`=8'hA5.
  - After release with `d`=8'h3C -> `q`=8'h3C one edge later.
- Macro on: `rst` falls at t=8 with `d`=1 -> `q` stays 0 through the rising edges at t=9 and t=11; `q`=1 after the edge at t=13.
- Reset coincident with edge (macro off): `rst` falls exactly at the rising edge at t=9 -> `q` stays RESET_VALUE; first capture at t=11.
